// File: rtl/sopc_data_bus.sv
// rtl/sopc_data_bus.sv - data-side interconnect: address decode, one slave transaction at a time, stall/ack/timeout handling
module sopc_data_bus #(
  parameter int NUM_SLV = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int SEL_LSB = 28,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m_ce,
  input  logic                      m_we,
  input  logic [DATA_W/8-1:0]       m_sel,
  input  logic [ADDR_W-1:0]         m_addr,
  input  logic [DATA_W-1:0]         m_wdata,
  output logic [DATA_W-1:0]         m_rdata,
  output logic                      m_stall,
  output logic                      m_err,
  output logic [NUM_SLV-1:0]        s_ce,
  output logic                      s_we,
  output logic [DATA_W/8-1:0]       s_sel,
  output logic [ADDR_W-1:0]         s_addr,
  output logic [DATA_W-1:0]         s_wdata,
  input  logic [NUM_SLV*DATA_W-1:0] s_rdata,
  input  logic [NUM_SLV-1:0]        s_ack
);

  localparam int SEL_W  = DATA_W / 8;
  localparam int IDX_W  = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int FLD_W  = ADDR_W - SEL_LSB;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

  state_t              state_q, state_d;
  logic [NUM_SLV-1:0]  s_ce_q, s_ce_d;
  logic                s_we_q, s_we_d;
  logic [SEL_W-1:0]    s_sel_q, s_sel_d;
  logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
  logic [DATA_W-1:0]   m_rdata_q, m_rdata_d;
  logic                m_err_q, m_err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;

  // Everything from SEL_LSB upward is decoded, so set bits above the index field make an access unmapped.
  logic [FLD_W-1:0]    fld;
  logic                mapped;
  logic [IDX_W-1:0]    new_idx;
  logic                ack_hit;
  logic [DATA_W-1:0]   slv_rdata;
  logic [CNT_W-1:0]    cnt_inc;

  assign fld       = m_addr[ADDR_W-1:SEL_LSB];
  assign mapped    = ({1'b0, fld} < (FLD_W+1)'(NUM_SLV));
  assign new_idx   = fld[IDX_W-1:0];
  assign ack_hit   = s_ack[idx_q];
  assign slv_rdata = s_rdata[int'(idx_q)*DATA_W +: DATA_W];
  assign cnt_inc   = cnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    s_ce_d    = s_ce_q;
    s_we_d    = s_we_q;
    s_sel_d   = s_sel_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    m_rdata_d = m_rdata_q;
    m_err_d   = m_err_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (m_ce) begin
          s_we_d    = m_we;
          s_sel_d   = m_sel;
          s_addr_d  = m_addr;
          s_wdata_d = m_wdata;
          idx_d     = new_idx;
          cnt_d     = '0;
          if (mapped) begin
            s_ce_d          = '0;
            s_ce_d[new_idx] = 1'b1;
            state_d         = ST_BUSY;
          end else begin
            m_rdata_d = '0;
            m_err_d   = 1'b1;
            state_d   = ST_RESP;
          end
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_inc;
        // An ack arriving in the timeout cycle still completes cleanly.
        if (ack_hit) begin
          m_rdata_d = s_we_q ? '0 : slv_rdata;
          s_ce_d    = '0;
          state_d   = ST_RESP;
        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
          m_rdata_d = '0;
          m_err_d   = 1'b1;
          s_ce_d    = '0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        m_err_d = 1'b0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      s_ce_q    <= '0;
      s_we_q    <= 1'b0;
      s_sel_q   <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      m_rdata_q <= '0;
      m_err_q   <= 1'b0;
      cnt_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      s_ce_q    <= s_ce_d;
      s_we_q    <= s_we_d;
      s_sel_q   <= s_sel_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      m_rdata_q <= m_rdata_d;
      m_err_q   <= m_err_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
    end
  end

  assign m_stall = m_ce & (state_q != ST_RESP);
  assign m_rdata = m_rdata_q;
  assign m_err   = m_err_q;
  assign s_ce    = s_ce_q;
  assign s_we    = s_we_q;
  assign s_sel   = s_sel_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;

endmodule
